// File: rtl/gated_edge_counter.sv
// Gated rising-edge counter: counts edges of clean_i over a programmable gate window
// and hands each measurement to the consumer through a valid/ready handshake.
module gated_edge_counter #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned GATE_WIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clean_i,
  input  logic                  enable_i,
  input  logic [GATE_WIDTH-1:0] gate_len_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    HOLD
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   edge_cnt;
  logic                   ovf_sticky;
  logic [GATE_WIDTH-1:0]  timer;
  logic                   clean_prev;

  logic                   rise;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   ovf_next;
  logic [GATE_WIDTH-1:0]  timer_load;

  assign rise       = clean_i & ~clean_prev;
  // A zero gate length behaves as a one-cycle gate.
  assign timer_load = (gate_len_i == '0) ? '0 : gate_len_i - GATE_WIDTH'(1);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf_sticky;
    if (rise) begin
      if (&edge_cnt) ovf_next = 1'b1;
      else           cnt_next = edge_cnt + CNT_WIDTH'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      ovf_sticky <= 1'b0;
      timer      <= '0;
      clean_prev <= 1'b0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      clean_prev <= clean_i;
      case (state)
        IDLE: begin
          if (enable_i) begin
            state  <= ARM;
            busy_o <= 1'b1;
          end
        end
        ARM: begin
          edge_cnt   <= '0;
          ovf_sticky <= 1'b0;
          timer      <= timer_load;
          state      <= GATE;
        end
        GATE: begin
          if (!enable_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            edge_cnt   <= cnt_next;
            ovf_sticky <= ovf_next;
            if (timer == '0) begin
              // Final gate cycle: its own rise is already folded into cnt_next.
              state      <= HOLD;
              busy_o     <= 1'b0;
              valid_o    <= 1'b1;
              count_o    <= cnt_next;
              overflow_o <= ovf_next;
            end else begin
              timer <= timer - GATE_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            if (enable_i) begin
              state  <= ARM;
              busy_o <= 1'b1;
            end else begin
              state  <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gated_edge_counter.sv
// Bench for gated_edge_counter: a 16-bit and a 4-bit instance share all stimulus and
// are compared every cycle against a window/raw-count model plus literal expectations.
module tb_gated_edge_counter;

  localparam int GW = 20;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          clean_i;
  logic          enable_i;
  logic          ready_i;
  logic [GW-1:0] gate_len_i;

  logic [15:0] count16;
  logic        ovf16, valid16, busy16;
  logic [3:0]  count4;
  logic        ovf4, valid4, busy4;

  int n_tests = 0;
  int n_fail  = 0;
  int clean_mode = 0;  // 0 = driven directly, 1 = toggle every 5 cycles, 2 = every cycle

  always #5 clk_i = ~clk_i;

  gated_edge_counter #(.CNT_WIDTH(16), .GATE_WIDTH(GW)) dut16 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clean_i(clean_i), .enable_i(enable_i),
    .gate_len_i(gate_len_i), .count_o(count16), .overflow_o(ovf16),
    .valid_o(valid16), .ready_i(ready_i), .busy_o(busy16)
  );

  gated_edge_counter #(.CNT_WIDTH(4), .GATE_WIDTH(GW)) dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clean_i(clean_i), .enable_i(enable_i),
    .gate_len_i(gate_len_i), .count_o(count4), .overflow_o(ovf4),
    .valid_o(valid4), .ready_i(ready_i), .busy_o(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int raw, input int max_val);
    return (raw > max_val) ? max_val : raw;
  endfunction

  // Model: a measurement is an ARM slot, then a window of G sampled cycles whose raw
  // rise count is clamped per counter width, then a HOLD until accepted.
  bit m_started = 0;
  bit m_prev, m_arm, m_hold;
  int m_left, m_raw;
  int m_cnt16, m_cnt4;
  bit m_ovf16, m_ovf4;

  always @(posedge clk_i) begin
    bit rise;
    rise = clean_i && !m_prev;
    if (!rst_n_i) begin
      m_started = 1; m_prev = 0; m_arm = 0; m_hold = 0; m_left = 0; m_raw = 0;
      m_cnt16 = 0; m_cnt4 = 0; m_ovf16 = 0; m_ovf4 = 0;
    end else begin
      m_prev = clean_i;
      if (m_hold) begin
        if (ready_i) begin
          m_hold = 0;
          m_arm  = enable_i;
        end
      end else if (m_arm) begin
        m_arm  = 0;
        m_left = (gate_len_i == 0) ? 1 : int'(gate_len_i);
        m_raw  = 0;
      end else if (m_left > 0) begin
        if (!enable_i) m_left = 0;
        else begin
          m_raw += int'(rise);
          m_left--;
          if (m_left == 0) begin
            m_hold  = 1;
            m_cnt16 = sat(m_raw, 65535);
            m_ovf16 = (m_raw > 65535);
            m_cnt4  = sat(m_raw, 15);
            m_ovf4  = (m_raw > 15);
          end
        end
      end else if (enable_i) begin
        m_arm = 1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_started) begin
      check("valid16", valid16, m_hold);
      check("busy16",  busy16,  m_arm || (m_left > 0));
      check("count16", count16, m_cnt16);
      check("ovf16",   ovf16,   m_ovf16);
      check("valid4",  valid4,  m_hold);
      check("busy4",   busy4,   m_arm || (m_left > 0));
      check("count4",  count4,  m_cnt4);
      check("ovf4",    ovf4,    m_ovf4);
    end
  end

  // Clean-signal pattern generator for the periodic modes.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk_i); #1;
      if (clean_mode == 1) begin
        ph++;
        if (ph == 5) begin
          ph = 0;
          clean_i = !clean_i;
        end
      end else if (clean_mode == 2) begin
        clean_i = !clean_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string name, input int budget, output int waited);
    waited = 0;
    while (valid16 !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    check(name, valid16, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n_i = 0; clean_i = 0; enable_i = 0; ready_i = 0; gate_len_i = '0;
    ticks(2);
    rst_n_i = 1;
    check("rst_count", count16, 0);
    check("rst_valid", valid16, 0);
    check("rst_busy",  busy16,  0);
    check("rst_ovf",   ovf16,   0);

    // Nominal: G=100, 10-cycle clean period, consumer always ready.
    gate_len_i = 100; ready_i = 1; clean_mode = 1; enable_i = 1;
    wait_valid("t1_valid", 200, waited);
    check("t1_latency", waited, 102);
    check("t1_count16", count16, 10);
    check("t1_ovf16",   ovf16,   0);
    check("t1_count4",  count4,  10);
    tick();
    check("t1_valid_drop", valid16, 0);
    check("t1_rearm",      busy16,  1);

    // Abort mid-gate: previous result stays, no valid.
    enable_i = 0; clean_mode = 0; clean_i = 0;
    ticks(3);
    check("t5_abort_busy",  busy16,  0);
    check("t5_abort_valid", valid16, 0);
    check("t5_abort_count", count16, 10);

    // Rise on the final gate cycle is counted.
    gate_len_i = 8; enable_i = 1;
    tick();
    ticks(8);
    clean_i = 1;
    tick();
    enable_i = 0;
    check("t2_final_valid", valid16, 1);
    check("t2_final_count", count16, 1);
    clean_i = 0;
    tick();
    check("t2_idle_valid", valid16, 0);

    // Rise during the ARM cycle is not counted.
    enable_i = 1;
    tick();
    clean_i = 1;
    tick();
    ticks(8);
    enable_i = 0;
    check("t2_arm_valid", valid16, 1);
    check("t2_arm_count", count16, 0);
    clean_i = 0;
    tick();

    // Saturation of the 4-bit instance: 50 rises in a 100-cycle gate.
    gate_len_i = 100; clean_mode = 2; enable_i = 1;
    wait_valid("t3_valid", 200, waited);
    enable_i = 0; clean_mode = 0;
    check("t3_count4",  count4,  15);
    check("t3_ovf4",    ovf4,    1);
    check("t3_count16", count16, 50);
    check("t3_ovf16",   ovf16,   0);
    clean_i = 0;
    tick();

    // Backpressure, with gate_len_i changed mid-gate (takes effect next ARM).
    gate_len_i = 10; ready_i = 0; clean_mode = 1; enable_i = 1;
    ticks(5);
    gate_len_i = 3;
    wait_valid("t4_valid", 50, waited);
    check("t4_latency", waited + 5, 12);
    check("t4_count", count16, 1);
    ticks(20);
    check("t4_held_valid", valid16, 1);
    check("t4_held_busy",  busy16,  0);
    check("t4_held_count", count16, 1);
    ready_i = 1;
    tick();
    ready_i = 0;
    check("t4_accept_valid", valid16, 0);
    check("t4_accept_arm",   busy16,  1);
    wait_valid("t4_short_valid", 20, waited);
    check("t4_short_latency", waited, 4);

    // Reset during HOLD clears everything.
    rst_n_i = 0; enable_i = 0; clean_mode = 0; clean_i = 0;
    tick();
    rst_n_i = 1;
    check("t5_rst_valid",   valid16, 0);
    check("t5_rst_count16", count16, 0);
    check("t5_rst_count4",  count4,  0);
    check("t5_rst_busy",    busy16,  0);
    check("t5_rst_ovf",     ovf4,    0);

    // gate_len_i = 0 behaves as a one-cycle gate: valid three cycles after enable.
    gate_len_i = 0; ready_i = 1; enable_i = 1;
    ticks(2);
    check("t6_not_yet", valid16, 0);
    tick();
    check("t6_valid", valid16, 1);
    enable_i = 0;
    tick();
    check("t6_drop", valid16, 0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
